// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronizes the serial line, finds start edges, samples
// each bit at its centre using a 16x baud enable, and pushes the character plus status.
module uart_rx_deframer #(
   parameter int OSR         = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_en,
   input  logic       sin,
   input  logic [1:0] data_bits,
   input  logic       parity_en,
   input  logic       parity_even,
   input  logic       fifo_full,
   output logic       push,
   output logic [7:0] rx_data,
   output logic       parity_err,
   output logic       framing_err,
   output logic       break_det,
   output logic       overrun,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   localparam logic [3:0] SAMPLE_PT = 4'(OSR / 2 - 1);

   state_t                  state, state_nx;
   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    sin_s;
   logic                    prev_q;
   logic [3:0]              cnt;
   logic [2:0]              bidx;
   logic [7:0]              shreg;
   logic                    pbit;
   logic [1:0]              db_q;
   logic                    pe_q;
   logic                    pv_q;
   logic                    done_q;
   logic                    perr_pend;
   logic                    ferr_pend;
   logic                    brk_pend;
   logic                    start_edge;
   logic                    sample;
   logic                    last_bit;

   assign sin_s      = sync_q[SYNC_STAGES-1];
   assign start_edge = prev_q & ~sin_s;
   assign sample     = baud_en & (cnt == SAMPLE_PT);
   assign last_bit   = (bidx == {1'b1, db_q});
   assign busy       = (state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sin};
         prev_q <= sin_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (start_edge) state_nx = S_START;
         S_START:  if (sample) state_nx = sin_s ? S_IDLE : S_DATA;
         S_DATA:   if (sample && last_bit) state_nx = pe_q ? S_PARITY : S_STOP;
         S_PARITY: if (sample) state_nx = S_STOP;
         S_STOP:   if (sample) state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         bidx        <= '0;
         shreg       <= '0;
         pbit        <= 1'b0;
         db_q        <= '0;
         pe_q        <= 1'b0;
         pv_q        <= 1'b0;
         done_q      <= 1'b0;
         perr_pend   <= 1'b0;
         ferr_pend   <= 1'b0;
         brk_pend    <= 1'b0;
         push        <= 1'b0;
         overrun     <= 1'b0;
         rx_data     <= '0;
         parity_err  <= 1'b0;
         framing_err <= 1'b0;
         break_det   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // Frame config is captured at the start edge so mid-frame changes are ignored.
         if (state == S_IDLE && start_edge) begin
            cnt   <= '0;
            bidx  <= '0;
            shreg <= '0;
            pbit  <= 1'b0;
            db_q  <= data_bits;
            pe_q  <= parity_en;
            pv_q  <= parity_even;
         end else if (state != S_IDLE && baud_en) begin
            cnt <= cnt + 4'd1;
         end

         if (sample) begin
            case (state)
               S_DATA: begin
                  shreg[bidx] <= sin_s;
                  bidx        <= bidx + 3'd1;
               end
               S_PARITY: pbit <= sin_s;
               S_STOP: begin
                  done_q    <= 1'b1;
                  ferr_pend <= ~sin_s;
                  brk_pend  <= (shreg == 8'd0) & ~pbit & ~sin_s;
                  perr_pend <= pe_q & ((^{shreg, pbit}) != ~pv_q);
               end
               default: ;
            endcase
         end

         push    <= done_q & ~fifo_full;
         overrun <= done_q & fifo_full;
         if (done_q && !fifo_full) begin
            rx_data     <= shreg;
            parity_err  <= perr_pend;
            framing_err <= ferr_pend;
            break_det   <= brk_pend;
         end
      end
   end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Receive-side serial engine of the UART: deframes the asynchronous serial input `sin` using a 16x-oversampled baud enable.
- Checks parity, stop bit and break condition on each character.
- Pushes each received character and its status into the RX FIFO with a single-cycle push.
- Counterpart to the TX path: consumes the line format the transmitter produces.

Parameters:
- OSR, 16, oversample ticks per bit (fixed; sample counter is 4 bits).
- SYNC_STAGES, 2, flops in the `sin` synchronizer.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- baud_en  input  1  one-clk pulse at 16x bit rate.
- sin  input  1  serial line; idles high.
- data_bits  input  2  word length: 00=5, 01=6, 10=7, 11=8.
- parity_en  input  1  parity bit present.
- parity_even  input  1  1=even parity, 0=odd parity.
- fifo_full  input  1  RX FIFO cannot accept a push.
- push  output  1  one-clk write strobe to RX FIFO.
- rx_data  output  8  received char, LSB-aligned, unused MSBs 0.
- parity_err  output  1  status for char on `rx_data`; valid with `push`.
- framing_err  output  1  stop bit sampled 0; valid with `push`.
- break_det  output  1  break character; valid with `push`.
- overrun  output  1  one-clk pulse: char completed while `fifo_full`.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- **Reset:**
  - While `rst`=1 the FSM is in IDLE.
  - `push`, `overrun`, `busy`, `rx_data`, `parity_err`, `framing_err`, `break_det` are all 0.
  - Synchronizer flops and the previous-sample flop are set to 1.
  - Reset mid-frame abandons the frame; no push occurs.
- **Sync:** `sin` passes through SYNC_STAGES flops (`sin_s`); all decisions use `sin_s`.
- **Sample counter:**
  - `cnt` is 4 bits, cleared on start detection, incremented on each `baud_en` while not IDLE, wraps 15->0.
  - A bit is sampled when `baud_en` && `cnt`==7 (bit centre).
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** a falling edge on `sin_s` (previous 1, current 0) -> START; clear `cnt`.
    - At the same clock, latch `data_bits`, `parity_en`, `parity_even`; config changes mid-frame have no effect.
  - **START:** at the sample point, `sin_s`=1 -> IDLE (false start, no push); `sin_s`=0 -> DATA with bit index 0.
  - **DATA:**
    - At each sample point, write `sin_s` into the shift register at the bit index (LSB first).
    - After bit N-1 (N=5..8): go to PARITY if parity is enabled, else STOP.
  - **PARITY:** sample the parity bit.
    - Parity error = `parity_en` & (XOR(data bits, parity bit) != (`parity_even` ? 0 : 1)).
  - **STOP:**
    - At the sample point, record framing error = ~`sin_s`.
    - Record break = (all data bits 0) & (parity bit 0 or parity off) & (`sin_s`==0).
    - Go to IDLE in the same cycle; a second stop bit is not checked.
    - Next start edge detection is allowed immediately (back-to-back chars at full rate).
- **Completion:** one clk after the STOP sample, if `fifo_full`=0:
  - `push`=1 for exactly 1 clk.
  - `rx_data` and the three status flags update in that same cycle.
  - They hold until the next completion.
- **Overrun:** if `fifo_full`=1 at completion:
  - No push; `overrun`=1 for 1 clk.
  - `rx_data` and flags keep their previous values; the char is discarded.
- **After framing error/break:** the line may stay low; a new start requires `sin_s` to return high and fall again, which the edge detection enforces.
- **`baud_en` timing:** the FSM never advances without `baud_en`; holding `baud_en` low freezes the frame.
- Frame latency: start edge to `push` = 2 (sync) + (1 + N + P + 0.5) bit-times + 1 clk, where P = 1 if parity is enabled, else 0.

Test Plan:
- 8N1, drive 0xA5 at 16x rate -> one push; `rx_data`=0xA5; all flags 0; `busy` low after the stop bit centre.
- 7E1, drive 0x35 with parity bit 1 (wrong) -> push; `rx_data`=0x35; `parity_err`=1. Repeat with parity 0 -> `parity_err`=0.
- Glitch: `sin` low for 4 `baud_en` ticks then high -> no push; FSM back in IDLE. A following valid 0x3C frame is received correctly.
- 8N1, 0x00 with stop bit 0, line held low 3 bit-times -> one push; `rx_data`=0x00; `framing_err`=1; `break_det`=1. No further push until the line goes high then low again.
- Overrun: `fifo_full`=1 during a 0x55 frame -> `push` stays 0; `overrun` is a 1-clk pulse; `rx_data` keeps the previous 0xA5.
- Reset mid-data at bit 3, then release, then send 0x81 (5-bit mode: 0x01) -> no push for the aborted frame; the next frame is received correctly with upper bits 0.
